// File: rtl/eq_coeff_bank.sv
// eq_coeff_bank: double-buffered biquad coefficient store for the equalizer.
// The equalizer reads the active bank with one cycle of latency while a host
// streams a complete new set into the shadow bank; the banks swap only on
// swap_sync once a well-formed set has been received. Both banks are filled
// with unity (pass-through) biquads after reset.
// Optional feature macro: EQ_COEFF_CHECKSUM_EN (publishes a modulo-2^W sum of
// each cleanly loaded set on load_checksum; tied to 0 when undefined).
module eq_coeff_bank #(
   parameter int  NR_CHANNELS    = 3,
   parameter int  NR_EQ_BANDS    = 8,
   parameter int  EQ_COEFF_WIDTH = 32,
   localparam int NR_EQ_COEFF    = NR_CHANNELS * NR_EQ_BANDS * 5,
   localparam int ADDR_WIDTH     = $clog2(NR_EQ_COEFF)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [ADDR_WIDTH-1:0]     eq_coeff_addr,
   output logic [EQ_COEFF_WIDTH-1:0] eq_coeff,
   input  logic [EQ_COEFF_WIDTH-1:0] s_tdata,
   input  logic                      s_tvalid,
   output logic                      s_tready,
   input  logic                      s_tlast,
   input  logic                      swap_sync,
   output logic                      busy,
   output logic                      active_bank,
   output logic                      load_error,
   output logic [EQ_COEFF_WIDTH-1:0] load_checksum
);

   localparam logic [EQ_COEFF_WIDTH-1:0] UNITY = EQ_COEFF_WIDTH'(1) << (EQ_COEFF_WIDTH - 4);

   typedef enum logic [1:0] {INIT, LOAD, PENDING} state_t;

   state_t                    state, state_next;
   logic [ADDR_WIDTH-1:0]     cnt;
   logic                      cnt_last;
   logic                      addr_oob;
   logic                      init_wr, load_wr, load_done, load_err, do_swap;

   logic [EQ_COEFF_WIDTH-1:0] bank0 [NR_EQ_COEFF];
   logic [EQ_COEFF_WIDTH-1:0] bank1 [NR_EQ_COEFF];

   // Coefficient order per band is A0, A1, A2, -B1, -B2: only A0 is non-zero.
   function automatic logic [EQ_COEFF_WIDTH-1:0] unity_coeff(input logic [ADDR_WIDTH-1:0] addr);
      int a;
      a = int'(addr);
      return (a % 5 == 0) ? UNITY : '0;
   endfunction

   assign cnt_last = (cnt == ADDR_WIDTH'(NR_EQ_COEFF - 1));
   assign addr_oob = ({1'b0, eq_coeff_addr} >= (ADDR_WIDTH + 1)'(NR_EQ_COEFF));

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= INIT;
      else        state <= state_next;
   end

   // Next-state decode, handshake outputs and per-cycle write/swap strobes
   always_comb begin
      state_next = state;
      s_tready   = 1'b0;
      busy       = 1'b0;
      init_wr    = 1'b0;
      load_wr    = 1'b0;
      load_done  = 1'b0;
      load_err   = 1'b0;
      do_swap    = 1'b0;
      case (state)
         INIT: begin
            init_wr = 1'b1;
            if (cnt_last) state_next = LOAD;
         end
         LOAD: begin
            s_tready = 1'b1;
            if (s_tvalid) begin
               load_wr = 1'b1;
               if (s_tlast && cnt_last) begin
                  load_done  = 1'b1;
                  state_next = PENDING;
               end else if (s_tlast || cnt_last) begin
                  load_err = 1'b1;
               end
            end
         end
         PENDING: begin
            busy = 1'b1;
            if (swap_sync) begin
               do_swap    = 1'b1;
               state_next = LOAD;
            end
         end
         default: state_next = INIT;
      endcase
   end

   // Shared counter: init walk address in INIT, shadow write address in LOAD
   always_ff @(posedge clk) begin
      if (!rst_n)                         cnt <= '0;
      else if (init_wr)                   cnt <= cnt_last ? '0 : cnt + 1'b1;
      else if (load_done || load_err)     cnt <= '0;
      else if (load_wr)                   cnt <= cnt + 1'b1;
      else if (do_swap)                   cnt <= '0;
   end

   // Bank select toggles only at a safe swap point; error pulse is registered
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         active_bank <= 1'b0;
         load_error  <= 1'b0;
      end else begin
         load_error <= load_err;
         if (do_swap) active_bank <= ~active_bank;
      end
   end

   // Bank 0 write port: unity fill during INIT, otherwise only while it is the shadow
   always_ff @(posedge clk) begin
      if (init_wr)                     bank0[cnt] <= unity_coeff(cnt);
      else if (load_wr && active_bank) bank0[cnt] <= s_tdata;
   end

   // Bank 1 write port: unity fill during INIT, otherwise only while it is the shadow
   always_ff @(posedge clk) begin
      if (init_wr)                      bank1[cnt] <= unity_coeff(cnt);
      else if (load_wr && !active_bank) bank1[cnt] <= s_tdata;
   end

   // Registered read; during INIT the unity pattern is computed so RAM is never exposed
   always_ff @(posedge clk) begin
      if (!rst_n)             eq_coeff <= '0;
      else if (addr_oob)      eq_coeff <= '0;
      else if (state == INIT) eq_coeff <= unity_coeff(eq_coeff_addr);
      else if (active_bank)   eq_coeff <= bank1[eq_coeff_addr];
      else                    eq_coeff <= bank0[eq_coeff_addr];
   end

`ifdef EQ_COEFF_CHECKSUM_EN
   logic [EQ_COEFF_WIDTH-1:0] sum;

   // Running sum of the set in flight, published when a set completes cleanly
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum           <= '0;
         load_checksum <= '0;
      end else if (load_done) begin
         load_checksum <= sum + s_tdata;
         sum           <= '0;
      end else if (load_err) begin
         sum <= '0;
      end else if (load_wr) begin
         sum <= sum + s_tdata;
      end else if (state_next == LOAD && state != LOAD) begin
         sum <= '0;
      end
   end
`else
   assign load_checksum = '0;
`endif

endmodule

// File: tb/tb_eq_coeff_bank.sv
// Scoreboard bench for eq_coeff_bank: the driver updates a transaction-level
// reference model and queues the expected outputs for every clock edge; an
// independent monitor pops and compares one entry after each rising edge.
module tb_eq_coeff_bank;

   localparam int N     = 120;
   localparam int W     = 32;
   localparam int AW    = 7;
   localparam logic [W-1:0] UNITY = 32'h1000_0000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] eq_coeff_addr = '0;
   logic [W-1:0]  eq_coeff;
   logic [W-1:0]  s_tdata = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tready;
   logic          s_tlast = 1'b0;
   logic          swap_sync = 1'b0;
   logic          busy;
   logic          active_bank;
   logic          load_error;
   logic [W-1:0]  load_checksum;

   eq_coeff_bank dut (
      .clk(clk), .rst_n(rst_n), .eq_coeff_addr(eq_coeff_addr), .eq_coeff(eq_coeff),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
      .swap_sync(swap_sync), .busy(busy), .active_bank(active_bank),
      .load_error(load_error), .load_checksum(load_checksum)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] eq;
      logic         tready;
      logic         busy;
      logic         act;
      logic         err;
      logic [W-1:0] ck;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model: phase 0 = initialising, 1 = accepting a set, 2 = set waiting for swap
   int           m_phase = 0;
   int           m_idx = 0;
   int           m_act = 0;
   logic [W-1:0] m_bank [2][N];
   logic [W-1:0] m_sum = '0;
   logic [W-1:0] m_ck = '0;

   function automatic logic [W-1:0] unity_of(input int a);
      return (a % 5 == 0) ? UNITY : '0;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: one expectation per rising edge, compared just after it
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("eq_coeff",      eq_coeff,            e.eq);
         chk("s_tready",      {31'b0, s_tready},   {31'b0, e.tready});
         chk("busy",          {31'b0, busy},       {31'b0, e.busy});
         chk("active_bank",   {31'b0, active_bank},{31'b0, e.act});
         chk("load_error",    {31'b0, load_error}, {31'b0, e.err});
         chk("load_checksum", load_checksum,       e.ck);
      end
   end

   // Drive one clock of inputs and record what the outputs must be after the edge
   task automatic cycle(input bit r, input bit v, input logic [W-1:0] d, input bit l,
                        input bit sw, input logic [AW-1:0] a);
      exp_t e;
      int   ai;
      @(negedge clk);
      rst_n = r; s_tvalid = v; s_tdata = d; s_tlast = l; swap_sync = sw; eq_coeff_addr = a;
      ai = int'(a);
      if (!r || ai >= N)    e.eq = '0;
      else if (m_phase == 0) e.eq = unity_of(ai);
      else                   e.eq = m_bank[m_act][ai];
      e.err = 1'b0;
      if (!r) begin
         m_phase = 0; m_idx = 0; m_act = 0; m_sum = '0; m_ck = '0;
      end else if (m_phase == 0) begin
         m_bank[0][m_idx] = unity_of(m_idx);
         m_bank[1][m_idx] = unity_of(m_idx);
         if (m_idx == N - 1) begin m_phase = 1; m_idx = 0; m_sum = '0; end
         else m_idx++;
      end else if (m_phase == 1) begin
         if (v) begin
            m_bank[1 - m_act][m_idx] = d;
            if (l && m_idx == N - 1) begin
               m_phase = 2; m_ck = m_sum + d; m_sum = '0; m_idx = 0;
            end else if (l || m_idx == N - 1) begin
               e.err = 1'b1; m_idx = 0; m_sum = '0;
            end else begin
               m_sum = m_sum + d; m_idx++;
            end
         end
      end else if (sw) begin
         m_act = 1 - m_act; m_phase = 1; m_idx = 0; m_sum = '0;
      end
      e.tready = (m_phase == 1);
      e.busy   = (m_phase == 2);
      e.act    = m_act[0];
`ifdef EQ_COEFF_CHECKSUM_EN
      e.ck     = m_ck;
`else
      e.ck     = '0;
`endif
      q.push_back(e);
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      return AW'($urandom_range(0, 127));
   endfunction

   task automatic idle(input int n, input bit rand_swap);
      for (int i = 0; i < n; i++)
         cycle(1'b1, 1'b0, $urandom, 1'b0, rand_swap ? 1'(($urandom & 32'h3) == 0) : 1'b0, rnd_addr());
   endtask

   // Stream a set: nbeats accepted beats, s_tlast on beat last_at (0 = never);
   // rst_at > 0 asserts reset for two cycles before that beat and abandons the set
   task automatic send_set(input int nbeats, input int last_at, input bit idx_data, input int rst_at);
      int b = 0;
      int guard = 0;
      while (m_phase != 1 && guard < 300) begin
         idle(1, 1'b0);
         guard++;
      end
      if (m_phase != 1) begin
         errors++;
         $display("FAIL load_wait: model never reached load phase");
      end
      while (b < nbeats) begin
         bit           v;
         logic [W-1:0] d;
         if (rst_at > 0 && b == rst_at) begin
            cycle(1'b0, 1'b1, $urandom, 1'b0, 1'b0, rnd_addr());
            cycle(1'b0, 1'b0, $urandom, 1'b0, 1'b0, rnd_addr());
            return;
         end
         v = ($urandom_range(0, 3) != 0);
         d = idx_data ? W'(b) : $urandom;
         cycle(1'b1, v, d, v ? (b + 1 == last_at) : 1'($urandom), 1'b0, rnd_addr());
         if (v) b++;
      end
   endtask

   task automatic swap_pulse();
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b1, AW'(7));
   endtask

   initial begin
      // Reset, then the unity initialisation walk with stray swap strobes
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, rnd_addr());
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, AW'(0));
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, AW'(1));
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, AW'(5));
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, AW'(120));
      idle(124, 1'b1);

      // Index-valued set, hold pending, then swap and read back
      send_set(N, N, 1'b1, 0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, AW'(7));
      swap_pulse();
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, AW'(7));
      idle(20, 1'b0);

      // Early s_tlast, ignored swap in LOAD, then a good random set
      send_set(50, 50, 1'b0, 0);
      swap_pulse();
      send_set(N, N, 1'b0, 0);
      idle(3, 1'b0);
      swap_pulse();
      idle(20, 1'b0);

      // Missing s_tlast, ignored swap, then a good set to make bank 1 active
      send_set(N, 0, 1'b0, 0);
      swap_pulse();
      send_set(N, N, 1'b0, 0);
      swap_pulse();
      idle(20, 1'b0);

      // Reset in the middle of a load, INIT reruns
      send_set(N, N, 1'b0, 60);
      idle(140, 1'b1);

      // One more index-valued set after re-initialisation
      send_set(N, N, 1'b1, 0);
      swap_pulse();
      idle(20, 1'b0);

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      #2;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left unchecked", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
